// File: rtl/branch_resolve_unit.sv
// In-order branch queue: records predicted branches at decode, pairs them with execute
// resolutions, and emits one registered predictor update per resolution. Optional: BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       issue_valid,
  input  logic [1:0] issue_addr,
  input  logic [1:0] issue_offset,
  input  logic       issue_pred,
  output logic       issue_ready,
  input  logic       resolve_valid,
  input  logic       resolve_taken,
  output logic       update,
  output logic [1:0] buffer_addr,
  output logic [1:0] buffer_offset,
  output logic       branch_result,
  output logic       mispredict,
  output logic       empty
`ifdef BRU_STATS_EN
  ,
  output logic [15:0] resolve_count,
  output logic [15:0] mispredict_count,
  output logic [7:0]  underflow_count
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [1:0]       addr_q   [DEPTH];
  logic [1:0]       offset_q [DEPTH];
  logic             pred_q   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             update_q;
  logic             mispredict_q;
  logic [1:0]       baddr_q;
  logic [1:0]       boffset_q;
  logic             result_q;

  logic             push;
  logic             pop;
  logic             miss;

`ifdef BRU_STATS_EN
  logic [15:0]      resolve_cnt_q;
  logic [15:0]      mispredict_cnt_q;
  logic [7:0]       underflow_cnt_q;
`endif

  assign issue_ready = (count_q != FULL_CNT);
  assign empty       = (count_q == '0);

  always_comb begin
    pop     = resolve_valid && (count_q != '0);
    push    = issue_valid && issue_ready;
    miss    = pop && (resolve_taken != pred_q[head_q]);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (miss) begin
      // Wrong-path flush: everything behind head, including a same-cycle push, is dropped.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]   <= '0;
        offset_q[i] <= '0;
        pred_q[i]   <= 1'b0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      update_q     <= 1'b0;
      mispredict_q <= 1'b0;
      baddr_q      <= '0;
      boffset_q    <= '0;
      result_q     <= 1'b0;
`ifdef BRU_STATS_EN
      resolve_cnt_q    <= '0;
      mispredict_cnt_q <= '0;
      underflow_cnt_q  <= '0;
`endif
    end else begin
      if (push && !miss) begin
        addr_q[tail_q]   <= issue_addr;
        offset_q[tail_q] <= issue_offset;
        pred_q[tail_q]   <= issue_pred;
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      update_q     <= pop;
      mispredict_q <= miss;
      // Data outputs hold between updates so the predictor sees stable values.
      if (pop) begin
        baddr_q   <= addr_q[head_q];
        boffset_q <= offset_q[head_q];
        result_q  <= resolve_taken;
      end
`ifdef BRU_STATS_EN
      if (pop && (resolve_cnt_q != '1))
        resolve_cnt_q <= resolve_cnt_q + 1'b1;
      if (miss && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      if (resolve_valid && (count_q == '0) && (underflow_cnt_q != '1))
        underflow_cnt_q <= underflow_cnt_q + 1'b1;
`endif
    end
  end

  assign update        = update_q;
  assign mispredict    = mispredict_q;
  assign buffer_addr   = baddr_q;
  assign buffer_offset = boffset_q;
  assign branch_result = result_q;

`ifdef BRU_STATS_EN
  assign resolve_count    = resolve_cnt_q;
  assign mispredict_count = mispredict_cnt_q;
  assign underflow_count  = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit; reference model is a queue of pending branches.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [1:0] issue_addr = '0;
  logic [1:0] issue_offset = '0;
  logic       issue_pred = 1'b0;
  logic       issue_ready;
  logic       resolve_valid = 1'b0;
  logic       resolve_taken = 1'b0;
  logic       update;
  logic [1:0] buffer_addr;
  logic [1:0] buffer_offset;
  logic       branch_result;
  logic       mispredict;
  logic       empty;
`ifdef BRU_STATS_EN
  logic [15:0] resolve_count;
  logic [15:0] mispredict_count;
  logic [7:0]  underflow_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] o;
    logic       p;
  } ent_t;

  ent_t       mq[$];
  logic       m_upd, m_mis, m_res;
  logic [1:0] m_addr, m_off;
  int         m_rc, m_mc, m_uc;

  always #5 clock = ~clock;

  branch_resolve_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_offset(issue_offset),
    .issue_pred(issue_pred), .issue_ready(issue_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .update(update), .buffer_addr(buffer_addr), .buffer_offset(buffer_offset),
    .branch_result(branch_result), .mispredict(mispredict), .empty(empty)
`ifdef BRU_STATS_EN
    , .resolve_count(resolve_count), .mispredict_count(mispredict_count),
    .underflow_count(underflow_count)
`endif
  );

  task automatic model_reset();
    mq.delete();
    m_upd = 0; m_mis = 0; m_res = 0; m_addr = 0; m_off = 0;
    m_rc = 0; m_mc = 0; m_uc = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic cycle(input logic iv, input logic [1:0] ia, input logic [1:0] io,
                       input logic ip, input logic rv, input logic rt);
    ent_t e;
    bit   pop, push;
    issue_valid = iv; issue_addr = ia; issue_offset = io; issue_pred = ip;
    resolve_valid = rv; resolve_taken = rt;
    if (reset_n) begin
      pop  = rv && (mq.size() > 0);
      push = iv && (mq.size() < DEPTH);
      if (rv && mq.size() == 0 && m_uc < 255) m_uc++;
      m_upd = pop;
      m_mis = 0;
      if (pop) begin
        e = mq.pop_front();
        m_addr = e.a; m_off = e.o; m_res = rt;
        m_mis = (rt != e.p);
        if (m_rc < 65535) m_rc++;
        if (m_mis) begin
          mq.delete();
          if (m_mc < 65535) m_mc++;
        end
      end
      if (push && !m_mis) mq.push_back('{a: ia, o: io, p: ip});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    idle(); idle();
    n_total++; if (update !== 1'b0) $display("FAIL rst_update got=%b exp=0", update); else n_pass++;
    n_total++; if (issue_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", issue_ready); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", empty); else n_pass++;
    n_total++; if ({buffer_addr, buffer_offset, branch_result} !== 5'd0)
      $display("FAIL rst_data got=%b exp=0", {buffer_addr, buffer_offset, branch_result}); else n_pass++;
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle();
      n_total++; if (issue_ready !== 1'b1) $display("FAIL idle_ready cyc=%0d got=%b exp=1", i, issue_ready); else n_pass++;
      n_total++; if (empty !== 1'b1) $display("FAIL idle_empty cyc=%0d got=%b exp=1", i, empty); else n_pass++;
      n_total++; if (update !== 1'b0) $display("FAIL idle_update cyc=%0d got=%b exp=0", i, update); else n_pass++;
      n_total++; if (mispredict !== 1'b0) $display("FAIL idle_mis cyc=%0d got=%b exp=0", i, mispredict); else n_pass++;
    end
  endtask

  task automatic test_fill_drain();
    logic [1:0] pa[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] po[4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic       pp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_rdy;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, pa[i], po[i], pp[i], 1'b0, 1'b0);
      exp_rdy = (i < 3);
      n_total++; if (issue_ready !== exp_rdy) $display("FAIL fill_ready n=%0d got=%b exp=%b", i, issue_ready, exp_rdy); else n_pass++;
    end
    cycle(1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    n_total++; if (issue_ready !== 1'b0) $display("FAIL held_ready got=%b exp=0", issue_ready); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL held_empty got=%b exp=0", empty); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, pp[i]);
      n_total++; if (update !== 1'b1) $display("FAIL drain_update n=%0d got=%b exp=1", i, update); else n_pass++;
      n_total++; if ({buffer_addr, buffer_offset, branch_result} !== {pa[i], po[i], pp[i]})
        $display("FAIL drain_data n=%0d got=%b exp=%b", i, {buffer_addr, buffer_offset, branch_result}, {pa[i], po[i], pp[i]});
      else n_pass++;
      n_total++; if (mispredict !== 1'b0) $display("FAIL drain_mis n=%0d got=%b exp=0", i, mispredict); else n_pass++;
    end
    n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else n_pass++;
    idle();
    n_total++; if (update !== 1'b0) $display("FAIL drain_after_update got=%b exp=0", update); else n_pass++;
  endtask

  task automatic test_mispredict();
    cycle(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    n_total++; if (update !== 1'b1) $display("FAIL mis_update got=%b exp=1", update); else n_pass++;
    n_total++; if (mispredict !== 1'b1) $display("FAIL mis_strobe got=%b exp=1", mispredict); else n_pass++;
    n_total++; if ({buffer_addr, buffer_offset, branch_result} !== 5'b01_01_1)
      $display("FAIL mis_data got=%b exp=01011", {buffer_addr, buffer_offset, branch_result}); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL mis_squash_empty got=%b exp=1", empty); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_total++; if (update !== 1'b0) $display("FAIL mis_after_update n=%0d got=%b exp=0", i, update); else n_pass++;
      n_total++; if (mispredict !== 1'b0) $display("FAIL mis_after_strobe n=%0d got=%b exp=0", i, mispredict); else n_pass++;
      n_total++; if (empty !== 1'b1) $display("FAIL mis_after_empty n=%0d got=%b exp=1", i, empty); else n_pass++;
    end
  endtask

  task automatic test_full_concurrent();
    logic [1:0] ea[4] = '{2'd2, 2'd3, 2'd0, 2'd3};
    logic [1:0] eo[4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    cycle(1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1);
    n_total++; if ({update, mispredict} !== 2'b10) $display("FAIL fc_update got=%b exp=10", {update, mispredict}); else n_pass++;
    n_total++; if ({buffer_addr, buffer_offset} !== 4'b01_00) $display("FAIL fc_data got=%b exp=0100", {buffer_addr, buffer_offset}); else n_pass++;
    n_total++; if (issue_ready !== 1'b1) $display("FAIL fc_ready_after_pop got=%b exp=1", issue_ready); else n_pass++;
    cycle(1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    n_total++; if (issue_ready !== 1'b0) $display("FAIL fc_ready_refill got=%b exp=0", issue_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, mq[0].p);
      n_total++; if ({update, mispredict} !== 2'b10) $display("FAIL fc_drain_strobe n=%0d got=%b exp=10", i, {update, mispredict}); else n_pass++;
      n_total++; if ({buffer_addr, buffer_offset} !== {ea[i], eo[i]})
        $display("FAIL fc_drain_data n=%0d got=%b exp=%b", i, {buffer_addr, buffer_offset}, {ea[i], eo[i]}); else n_pass++;
    end
    n_total++; if (empty !== 1'b1) $display("FAIL fc_empty got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    n_total++; if (update !== 1'b1) $display("FAIL rm_pre_update got=%b exp=1", update); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_total++; if ({update, mispredict} !== 2'b00) $display("FAIL rm_strobes got=%b exp=00", {update, mispredict}); else n_pass++;
    n_total++; if ({buffer_addr, buffer_offset, branch_result} !== 5'd0)
      $display("FAIL rm_data got=%b exp=0", {buffer_addr, buffer_offset, branch_result}); else n_pass++;
    n_total++; if ({issue_ready, empty} !== 2'b11) $display("FAIL rm_ready_empty got=%b exp=11", {issue_ready, empty}); else n_pass++;
    idle();
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_total++; if ({update, empty} !== 2'b01) $display("FAIL rm_after n=%0d got=%b exp=01", i, {update, empty}); else n_pass++;
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    n_total++; if ({update, mispredict} !== 2'b00) $display("FAIL uf_strobes got=%b exp=00", {update, mispredict}); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL uf_empty got=%b exp=1", empty); else n_pass++;
`ifdef BRU_STATS_EN
    n_total++; if (underflow_count !== 8'd1) $display("FAIL uf_count got=%0d exp=1", underflow_count); else n_pass++;
    n_total++; if (resolve_count !== 16'd0) $display("FAIL uf_rcount got=%0d exp=0", resolve_count); else n_pass++;
`endif
    idle();
  endtask

  task automatic test_random();
    logic iv, ip, rv, rt;
    logic [1:0] ia, io;
    for (int i = 0; i < 400; i++) begin
      iv = ($urandom % 3) != 0;
      ia = 2'($urandom);
      io = 2'($urandom);
      ip = 1'($urandom);
      rv = ($urandom % 3) != 0;
      rt = (mq.size() > 0 && ($urandom % 4) != 0) ? mq[0].p : 1'($urandom);
      cycle(iv, ia, io, ip, rv, rt);
      n_total++; if (update !== m_upd) $display("FAIL rnd_update cyc=%0d got=%b exp=%b", i, update, m_upd); else n_pass++;
      n_total++; if (mispredict !== m_mis) $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", i, mispredict, m_mis); else n_pass++;
      n_total++; if ({buffer_addr, buffer_offset, branch_result} !== {m_addr, m_off, m_res})
        $display("FAIL rnd_data cyc=%0d got=%b exp=%b", i, {buffer_addr, buffer_offset, branch_result}, {m_addr, m_off, m_res});
      else n_pass++;
      n_total++; if (issue_ready !== (mq.size() != DEPTH)) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, issue_ready, mq.size() != DEPTH); else n_pass++;
      n_total++; if (empty !== (mq.size() == 0)) $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", i, empty, mq.size() == 0); else n_pass++;
`ifdef BRU_STATS_EN
      n_total++; if ({resolve_count, mispredict_count, underflow_count} !== {16'(m_rc), 16'(m_mc), 8'(m_uc)})
        $display("FAIL rnd_stats cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, resolve_count, mispredict_count, underflow_count, m_rc, m_mc, m_uc);
      else n_pass++;
`endif
    end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats_saturate();
    reset_n = 1'b0;
    model_reset();
    idle();
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 262; i++) cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    n_total++; if (underflow_count !== 8'hFF) $display("FAIL sat_underflow got=%0d exp=255", underflow_count); else n_pass++;
    n_total++; if (underflow_count !== 8'(m_uc)) $display("FAIL sat_model got=%0d exp=%0d", underflow_count, m_uc); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_mispredict();
    test_full_concurrent();
    test_reset_mid();
    test_underflow();
    test_random();
`ifdef BRU_STATS_EN
    test_stats_saturate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
